// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, zero-register constant and write-back request type
//
// Purpose : constants and types shared by the write-back arbiter and its requesters.
// Contents: REG_AW / REG_DW default widths, ZERO_REG (hard-wired zero register),
//           wb_req_t requester-side bundle, next_ptr round-robin helper.
package rf_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int next_ptr(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with one-hot and encoded grant
//
// Purpose : grant the first asserted request found searching from ptr_i upward, modulo N.
// Ports   : req_i       in  N   request vector
//           ptr_i       in  PW  search start index (must be < N)
//           gnt_o       out N   one-hot grant (all zero when no request)
//           gnt_id_o    out PW  encoded grant index (0 when no request)
//           gnt_valid_o out 1   some request was granted
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_id_o,
  output logic          gnt_valid_o
);

  always_comb begin
    int   idx;
    logic found;
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = PW'(idx);
        found      = 1'b1;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the register-file write port
//
// Purpose : arbitrate NREQ valid/ready write-back requesters onto one registered
//           register-file write port (we3/wa3/wd3) with a forwarding view.
// Ports   : clk        in  1        rising-edge clock
//           reset      in  1        synchronous active-high reset
//           req_valid  in  NREQ     requester i presents a write
//           req_addr   in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//           req_data   in  NREQ*DW  packed data, requester i at [i*DW +: DW]
//           req_ready  out NREQ     requester i accepted this cycle (combinational)
//           we3/wa3/wd3 out         registered register-file write port
//           fwd_valid  out 1        staged write visible for bypass (equals we3)
//           conflict   out 1        previous cycle had >=2 eligible requests to one address
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [DW-1:0]    wd3,
  output logic             fwd_valid,
  output logic             conflict
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] zero_req;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_id;
  logic            gnt_valid;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   wa3_q, wa3_d;
  logic [DW-1:0]   wd3_q, wd3_d;
  logic            conflict_q, conflict_d;

  // Address-0 writes are acknowledged and dropped: register 0 always reads as zero.
  always_comb begin
    elig     = '0;
    zero_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_addr[i*AW +: AW] == AW'(ZERO_REG)) begin
        zero_req[i] = req_valid[i];
      end else begin
        elig[i] = req_valid[i];
      end
    end
  end

  // Pairwise compare of eligible addresses; flagged one cycle later.
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (elig[i] && elig[j] && (req_addr[i*AW +: AW] == req_addr[j*AW +: AW])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .req_i       (elig),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    req_ready = reset ? '0 : (gnt | zero_req);
    rr_ptr_d  = rr_ptr_q;
    we3_d     = gnt_valid;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    if (gnt_valid) begin
      rr_ptr_d = PW'(next_ptr(int'(gnt_id), NREQ));
      wa3_d    = req_addr[int'(gnt_id)*AW +: AW];
      wd3_d    = req_data[int'(gnt_id)*DW +: DW];
    end
  end

  // Reset discards any staged write so the register file never sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      conflict_q <= conflict_d;
    end
  end

  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign fwd_valid = we3_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_req_t req_s [NREQ];

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we3;
  logic [AW-1:0]      wa3;
  logic [DW-1:0]      wd3;
  logic               fwd_valid;
  logic               conflict;

  always_comb begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = req_s[i].valid;
      req_addr[i*AW +: AW] = req_s[i].addr;
      req_data[i*DW +: DW] = req_s[i].data;
    end
  end

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .fwd_valid (fwd_valid),
    .conflict  (conflict)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q [$];
  wr_t mon_e;

  logic [DW-1:0] rf_model [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_s[i].valid = v;
    req_s[i].addr  = a;
    req_s[i].data  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Register file model: writes on the edge after we3 is seen, gated by reset.
  always @(posedge clk) begin
    if (we3 === 1'b1 && reset === 1'b0) rf_model[wa3] <= wd3;
  end

  // Monitor: every staged write must match the next expected write, in order.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got wa3=0x%0h wd3=0x%0h expected no write", wa3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_wa3", 64'(wa3), 64'(mon_e.addr));
        chk("mon_wd3", 64'(wd3), 64'(mon_e.data));
        chk("mon_fwd_valid", 64'(fwd_valid), 64'd1);
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    clear_reqs();

    // Reset held two cycles with all requesters valid.
    reset = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h1111_1111);
    set_req(1, 1'b1, 5'd2, 32'h2222_2222);
    set_req(2, 1'b1, 5'd3, 32'h3333_3333);
    tick();
    chk("rst_ready_c1", 64'(req_ready), 64'b000);
    tick();
    chk("rst_ready_c2", 64'(req_ready), 64'b000);
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_conflict", 64'(conflict), 64'd0);

    // Round-robin: grants 0,1,2 back to back.
    reset = 1'b0;
    settle();
    chk("rr_ready0", 64'(req_ready), 64'b001);
    expect_write(5'd1, 32'h1111_1111);
    tick();
    chk("rr_we3_a", 64'(we3), 64'd1);
    chk("rr_ready1", 64'(req_ready), 64'b010);
    expect_write(5'd2, 32'h2222_2222);
    tick();
    chk("rr_we3_b", 64'(we3), 64'd1);
    chk("rr_ready2", 64'(req_ready), 64'b100);
    expect_write(5'd3, 32'h3333_3333);
    tick();
    chk("rr_we3_c", 64'(we3), 64'd1);
    clear_reqs();
    settle();
    chk("rr_idle_ready", 64'(req_ready), 64'b000);
    tick();
    chk("rr_we3_drop", 64'(we3), 64'd0);

    // Single requester.
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    settle();
    chk("single_ready", 64'(req_ready), 64'b010);
    expect_write(5'd5, 32'hDEAD_BEEF);
    tick();
    clear_reqs();
    chk("single_we3", 64'(we3), 64'd1);
    chk("single_wa3", 64'(wa3), 64'd5);
    chk("single_wd3", 64'(wd3), 64'hDEAD_BEEF);
    chk("single_fwd", 64'(fwd_valid), 64'd1);
    tick();
    chk("single_we3_off", 64'(we3), 64'd0);

    // Address 0 is acked and dropped alongside a real grant.
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    set_req(2, 1'b1, 5'd7, 32'h7777_0007);
    settle();
    chk("zero_ready", 64'(req_ready), 64'b101);
    expect_write(5'd7, 32'h7777_0007);
    tick();
    clear_reqs();
    chk("zero_wa3", 64'(wa3), 64'd7);
    tick();
    chk("zero_we3_off", 64'(we3), 64'd0);
    chk("zero_rf0", 64'(rf_model[0]), 64'd0);

    // Same-address conflict, serialized 0 then 1.
    set_req(0, 1'b1, 5'd9, 32'h0000_000A);
    set_req(1, 1'b1, 5'd9, 32'h0000_000B);
    settle();
    chk("conf_ready0", 64'(req_ready), 64'b001);
    expect_write(5'd9, 32'h0000_000A);
    tick();
    chk("conf_pulse", 64'(conflict), 64'd1);
    set_req(0, 1'b0, '0, '0);
    settle();
    chk("conf_ready1", 64'(req_ready), 64'b010);
    expect_write(5'd9, 32'h0000_000B);
    tick();
    chk("conf_pulse_end", 64'(conflict), 64'd0);
    clear_reqs();
    tick();
    chk("conf_rf9", 64'(rf_model[9]), 64'h0000_000B);

    // Reset on the cycle after a grant: staged write lost, pointer back to 0.
    set_req(0, 1'b1, 5'd4, 32'h0000_0055);
    settle();
    chk("mid_ready", 64'(req_ready), 64'b001);
    expect_write(5'd4, 32'h0000_0055);
    tick();
    chk("mid_we3", 64'(we3), 64'd1);
    reset = 1'b1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b1, 5'd6, 32'h0000_0066);
    settle();
    chk("mid_rst_ready", 64'(req_ready), 64'b000);
    tick();
    chk("mid_we3_off", 64'(we3), 64'd0);
    chk("mid_wa3", 64'(wa3), 64'd0);
    chk("mid_rf4", 64'(rf_model[4]), 64'd0);
    reset = 1'b0;
    set_req(0, 1'b1, 5'd8, 32'h0000_0088);
    settle();
    chk("mid_ptr_reset", 64'(req_ready), 64'b001);
    expect_write(5'd8, 32'h0000_0088);
    tick();
    set_req(0, 1'b0, '0, '0);
    settle();
    chk("mid_ready_next", 64'(req_ready), 64'b010);
    expect_write(5'd6, 32'h0000_0066);
    tick();
    clear_reqs();
    tick();
    tick();
    chk("end_rf6", 64'(rf_model[6]), 64'h0000_0066);
    chk("end_rf8", 64'(rf_model[8]), 64'h0000_0088);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between NREQ write-back requesters, e.g. ALU result, load data and multi-cycle mul/div.
- Each requester uses a valid/ready handshake. A round-robin arbiter picks one request per cycle and stages it in an output register that drives the register file directly.
- A forwarding view of the staged write is exported, so read logic can bypass the one-cycle write delay.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i set: requester i presents a write.
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  bit i set: requester i's write is accepted this cycle (combinational).
- we3  out  1  register-file write enable (registered).
- wa3  out  AW  register-file write address (registered).
- wd3  out  DW  register-file write data (registered).
- fwd_valid  out  1  equals we3; the staged write is visible for bypass.
- conflict  out  1  registered pulse: in the previous cycle, two or more nonzero-address requests named the same address.

Behaviour:
- Reset: we3=0, wa3=0, wd3=0, fwd_valid=0, conflict=0, rr_ptr=0. Any staged write is discarded, not written.
- While reset is high, req_ready=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and its addr != 0.
- Address-0 requests: req_valid[i]=1 with addr==0 gets req_ready[i]=1 in the same cycle, is discarded and takes no part in arbitration. This matches register 0 being hard-wired to zero on read.
- Arbitration: among eligible requesters, grant the first found searching i = rr_ptr, rr_ptr+1, ... modulo NREQ. Exactly one grant per cycle.
- The granted requester sees req_ready=1. All other eligible requesters see req_ready=0 and must hold valid/addr/data stable until accepted.
- Acceptance: a handshake completes when valid && ready at a rising edge. Requesters must not drop valid before acceptance.
- Pointer update: after a grant to requester g, rr_ptr <= (g+1) mod NREQ. If there is no grant, rr_ptr holds.
- Staging, latency 1:
  - On an edge with a grant: we3<=1, wa3<=granted addr, wd3<=granted data.
  - On an edge without a grant: we3<=0; wa3 and wd3 hold their previous values.
  - The register file writes on the following edge, so accept-to-architectural-write is 2 edges.
- Forwarding: readers compare ra1/ra2 against wa3 when fwd_valid=1 and substitute wd3.
- Throughput: 1 write per cycle sustained. No bubble between back-to-back grants.
- Same address from multiple requesters in one cycle:
  - They are serialized in round-robin order.
  - The last one written wins.
  - conflict asserts for one cycle.
  - Ordering policy beyond this is the issuing logic's responsibility.
- Fairness: a continuously valid eligible requester is granted within NREQ cycles.
- Reset asserted mid-operation: a staged but unwritten entry is lost. Requesters must reissue after reset.

Decomposition:
- Shared package rf_pkg holds REG_AW=5, REG_DW=32 and ZERO_REG=0. It also holds a typedef wb_req_t {logic valid; logic [AW-1:0] addr; logic [DW-1:0] data;} for requester-side use.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs req[N], ptr;
  - outputs one-hot gnt[N] and encoded gnt_id.
  - It is purely combinational; the top block owns rr_ptr and the staging register.

Test Plan:
- Reset: hold reset 2 cycles with req_valid=3'b111 -> req_ready=0, we3=0, wa3=0, wd3=0, conflict=0. After release, the first grant goes to requester 0.
- Single requester: req1 addr=5, data=0xDEADBEEF for 1 cycle -> req_ready=3'b010 that cycle. Next cycle we3=1, wa3=5, wd3=0xDEADBEEF, fwd_valid=1. The cycle after that, we3=0.
- Round-robin: all 3 held valid with addrs 1,2,3 -> grants in order 0,1,2 on consecutive cycles. we3 stays 1 for 3 cycles with wa3 sequence 1,2,3.
- Address 0: req0 addr=0, data=0x1234, together with req2 addr=7 -> ready=3'b101 in the same cycle. Next cycle wa3=7; a write to register 0 never appears on we3.
- Conflict: req0 and req1 both addr=9, data 0xA and 0xB, rr_ptr=0 -> wd3 sequence 0xA then 0xB and conflict=1 for exactly one cycle. A read of register 9 returns 0xB.
- Reset mid-operation: assert reset on the cycle after a grant (we3=1) -> we3=0 next edge, no register-file write occurs, rr_ptr=0.
